// File: rtl/rs232_rxb.sv
// Buffered 8N1 RS232 receiver: 2-FF synchroniser, bit-timing FSM and show-ahead FIFO.
// Define RS232_RXB_FRAME_ERR_EN to discard frames whose stop bit is low and flag frame_err.
module rs232_rxb #(
    parameter int clock_freq = 50000000,
    parameter int num_slots  = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fsel,
    input  logic       rxd,
    input  logic       rd,
    input  logic       clr,
    output logic [7:0] data_out,
    output logic       empty,
    output logic       full,
    output logic       overrun,
    output logic       frame_err
);
    localparam int BitFastI = clock_freq / 115200;
    localparam int BitSlowI = clock_freq / 19200;
    localparam int CW = $clog2(BitSlowI + 1);
    localparam int PW = $clog2(num_slots);
    localparam int NW = $clog2(num_slots + 1);

    localparam logic [CW-1:0] BitFast  = CW'(BitFastI);
    localparam logic [CW-1:0] BitSlow  = CW'(BitSlowI);
    localparam logic [CW-1:0] HalfFast = CW'(BitFastI / 2);
    localparam logic [CW-1:0] HalfSlow = CW'(BitSlowI / 2);
    localparam logic [PW-1:0] LastPtr  = PW'(num_slots - 1);
    localparam logic [NW-1:0] Slots    = NW'(num_slots);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] tick_q;
    logic [CW-1:0] bit_q;
    logic [CW-1:0] half_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          push_q;
`ifdef RS232_RXB_FRAME_ERR_EN
    logic          fe_ev_q;
`endif

    logic          rxd_s;
    assign rxd_s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            tick_q  <= '0;
            bit_q   <= BitFast;
            half_q  <= HalfFast;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            push_q  <= 1'b0;
`ifdef RS232_RXB_FRAME_ERR_EN
            fe_ev_q <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[0], rxd};
            prev_q <= rxd_s;
            push_q <= 1'b0;
`ifdef RS232_RXB_FRAME_ERR_EN
            fe_ev_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // Only a real 1->0 transition starts a frame, so a held break is ignored.
                    if (prev_q && !rxd_s) begin
                        state_q <= START;
                        tick_q  <= '0;
                        bit_q   <= fsel ? BitFast : BitSlow;
                        half_q  <= fsel ? HalfFast : HalfSlow;
                    end
                end
                START: begin
                    if (tick_q == half_q - 1'b1) begin
                        tick_q <= '0;
                        idx_q  <= 3'd0;
                        state_q <= rxd_s ? IDLE : DATA;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == bit_q - 1'b1) begin
                        tick_q  <= '0;
                        shift_q <= {rxd_s, shift_q[7:1]};
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == bit_q - 1'b1) begin
                        tick_q  <= '0;
                        state_q <= IDLE;
`ifdef RS232_RXB_FRAME_ERR_EN
                        push_q  <= rxd_s;
                        fe_ev_q <= !rxd_s;
`else
                        push_q  <= 1'b1;
`endif
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [7:0]    mem_q [num_slots];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [NW-1:0] count_q;
    logic          overrun_q;
    logic          frame_err_q;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = rd && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_q && ((count_q != Slots) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
            if (push_q && !do_push) begin
                overrun_q <= 1'b1;
            end else if (clr) begin
                overrun_q <= 1'b0;
            end
`ifdef RS232_RXB_FRAME_ERR_EN
            if (fe_ev_q) begin
                frame_err_q <= 1'b1;
            end else if (clr) begin
                frame_err_q <= 1'b0;
            end
`endif
        end
    end

    assign empty     = (count_q == '0);
    assign full      = (count_q == Slots);
    assign data_out  = empty ? 8'h00 : mem_q[rptr_q];
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rs232_rxb.sv
// Randomised bench for rs232_rxb with a frame-level queue model checked every cycle.
module tb_rs232_rxb;
    localparam int CF = 2304000;
    localparam int N  = 63;
    localparam int BF = CF / 115200;
    localparam int BS = CF / 19200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fsel = 1'b1;
    logic       rxd = 1'b1;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       overrun;
    logic       frame_err;

    rs232_rxb #(.clock_freq(CF), .num_slots(N)) dut (
        .clk(clk), .rst(rst), .fsel(fsel), .rxd(rxd), .rd(rd), .clr(clr),
        .data_out(data_out), .empty(empty), .full(full),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int fall_cyc = -1;
    int rd_at = -1;
    int rd_pct = 0;
    int clr_pct = 0;
    bit rd_force = 1'b0;
    bit clr_force = 1'b0;

    logic [7:0] q_m[$];
    bit         ov_m = 1'b0;
    bit         fe_m = 1'b0;
    int         pend_c[$];
    logic [7:0] pend_b[$];
    bit         pend_ok[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Queue-level reference: a frame lands at its computed arrival cycle.
    task automatic model_step();
        bit pop;
        bit push;
        bit ferr;
        bit drop;
        logic [7:0] b;
        pop = rd && (q_m.size() > 0);
        push = 1'b0;
        ferr = 1'b0;
        b = 8'h00;
        if (pend_c.size() > 0 && pend_c[0] == cyc) begin
            b = pend_b[0];
`ifdef RS232_RXB_FRAME_ERR_EN
            push = pend_ok[0];
            ferr = !pend_ok[0];
`else
            push = 1'b1;
`endif
            void'(pend_c.pop_front());
            void'(pend_b.pop_front());
            void'(pend_ok.pop_front());
        end
        drop = push && !pop && (q_m.size() == N);
        if (pop) void'(q_m.pop_front());
        if (push && !drop) q_m.push_back(b);
        ov_m = drop ? 1'b1 : (clr ? 1'b0 : ov_m);
        fe_m = ferr ? 1'b1 : (clr ? 1'b0 : fe_m);
    endtask

    initial begin : monitor
        bit pe;
        pe = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) model_step();
            @(negedge clk);
            if (rst) begin
                q_m.delete();
                pend_c.delete();
                pend_b.delete();
                pend_ok.delete();
                ov_m = 1'b0;
                fe_m = 1'b0;
            end
            cmp("empty", empty, q_m.size() == 0);
            cmp("full", full, q_m.size() == N);
            if (q_m.size() > 0) cmp("data_out", data_out, q_m[0]);
            if (rst) cmp("rst_data_out", data_out, 8'h00);
            cmp("overrun", overrun, ov_m);
            cmp("frame_err", frame_err, fe_m);
            if (pe && !empty) fall_cyc = cyc;
            pe = empty;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd = rd_force || (rd_at == cyc + 1) || ($urandom_range(99) < rd_pct);
        clr = clr_force || ($urandom_range(99) < clr_pct);
    endtask

    task automatic pop1();
        rd_force = 1'b1;
        tick();
        rd_force = 1'b0;
        tick();
    endtask

    task automatic drain();
        rd_force = 1'b1;
        repeat (N + 2) tick();
        rd_force = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit fs,
                              input bit tog, input bit rd_on_push, output int n);
        int bt;
        int p;
        fsel = fs;
        bt = fs ? BF : BS;
        tick();
        n = cyc;
        p = n + 4 + bt / 2 + 9 * bt;
        pend_c.push_back(p);
        pend_b.push_back(b);
        pend_ok.push_back(stop);
        if (rd_on_push) rd_at = p;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) rxd = 1'b0;
            else if (i == 9) rxd = stop;
            else rxd = b[i-1];
            for (int k = 0; k < bt; k++) begin
                if (tog && i == 2 && k == 0) fsel = ~fsel;
                tick();
            end
        end
        if (!stop) repeat (30) tick();
        rxd = 1'b1;
        repeat ($urandom_range(10, 3)) tick();
    endtask

    initial begin : main
        int n;
        logic [7:0] rb;
        repeat (3) tick();
        cmp("reset_empty", empty, 1);
        cmp("reset_full", full, 0);
        cmp("reset_data", data_out, 8'h00);
        cmp("reset_overrun", overrun, 0);
        cmp("reset_frame_err", frame_err, 0);
        rst = 1'b0;
        tick();

        send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, n);
        cmp("t55_latency", fall_cyc - n, 194);
        cmp("t55_data", data_out, 8'h55);
        pop1();
        cmp("t55_empty", empty, 1);

        send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, n);
        cmp("tA3_latency", fall_cyc - n, 1144);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, n);
        cmp("order_A3", data_out, 8'hA3);
        pop1();
        cmp("order_00", data_out, 8'h00);
        pop1();
        cmp("order_empty", empty, 1);

        fsel = 1'b0;
        tick();
        rxd = 1'b0;
        repeat (40) tick();
        rxd = 1'b1;
        repeat (200) tick();
        cmp("false_start_empty", empty, 1);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, n);
        send_frame(8'hC6, 1'b1, 1'b1, 1'b1, 1'b0, n);
        cmp("after_false_start", data_out, 8'h3C);
        pop1();
        cmp("fsel_toggle", data_out, 8'hC6);
        pop1();

        for (int i = 0; i < 64; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0, 1'b0, n);
        cmp("fill_full", full, 1);
        cmp("fill_overrun", overrun, 1);
        for (int i = 0; i < 63; i++) begin
            cmp("fill_readback", data_out, 8'(i));
            pop1();
        end
        cmp("fill_drained", empty, 1);
        clr_force = 1'b1;
        tick();
        clr_force = 1'b0;
        tick();
        cmp("clr_overrun", overrun, 0);

        for (int i = 0; i < 63; i++) begin
            rb = 8'($urandom_range(255));
            send_frame(rb, 1'b1, 1'b1, 1'b0, 1'b0, n);
        end
        cmp("refill_full", full, 1);
        send_frame(8'h7E, 1'b1, 1'b1, 1'b0, 1'b1, n);
        cmp("rdpush_overrun", overrun, 0);
        cmp("rdpush_full", full, 1);
        repeat (62) pop1();
        cmp("rdpush_last", data_out, 8'h7E);
        pop1();
        cmp("rdpush_empty", empty, 1);

        send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, n);
`ifdef RS232_RXB_FRAME_ERR_EN
        cmp("ferr_flag", frame_err, 1);
        cmp("ferr_empty", empty, 1);
`else
        cmp("ferr_flag", frame_err, 0);
        cmp("ferr_data", data_out, 8'h41);
`endif

        fsel = 1'b1;
        tick();
        rb = 8'h99;
        rxd = 1'b0;
        repeat (BF) tick();
        for (int i = 0; i < 4; i++) begin
            rxd = rb[i];
            repeat (BF) tick();
        end
        rxd = rb[4];
        repeat (5) tick();
        rst = 1'b1;
        rxd = 1'b1;
        tick();
        cmp("midrst_empty", empty, 1);
        cmp("midrst_full", full, 0);
        cmp("midrst_data", data_out, 8'h00);
        cmp("midrst_overrun", overrun, 0);
        cmp("midrst_frame_err", frame_err, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        send_frame(8'h42, 1'b1, 1'b1, 1'b0, 1'b0, n);
        cmp("post_rst_data", data_out, 8'h42);
        cmp("post_rst_frame_err", frame_err, 0);
        pop1();

        rd_pct = 30;
        clr_pct = 5;
        repeat (30) begin
            rb = 8'($urandom_range(255));
            send_frame(rb, $urandom_range(9) != 0, $urandom_range(3) != 0,
                       1'($urandom_range(1)), 1'b0, n);
        end
        rd_pct = 0;
        clr_pct = 0;
        drain();
        cmp("final_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
